bidir_ram_sweep: RTL



---
 rtl/bidir_ram_sweep.sv | 111 +++++++++++
 1 files changed

// File: rtl/bidir_ram_sweep.sv
// Parametrised scratch RAM on a shared tri-state data bus with registered reads.
// A sweep engine zeroes the array after reset and fills it with PRESET_VAL on request.
module bidir_ram_sweep #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       ADDR_W     = 4,
    parameter logic [DATA_W-1:0] PRESET_VAL = '1
) (
    input  logic              clk,
    input  logic              reset,
    inout  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic              preset,
    output logic              busy,
    output logic              rd_valid,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_PRESET
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        mem_wa     = address;
        mem_wd     = data;

        case (state_q)
            ST_CLEAR, ST_PRESET: begin
                mem_we = 1'b1;
                mem_wa = ptr_q;
                mem_wd = (state_q == ST_CLEAR) ? '0 : PRESET_VAL;
                ptr_d  = ptr_q + 1'b1;
                err_d  = read | write | preset;
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Preset wins over any simultaneous access; the dropped access is flagged.
                if (preset) begin
                    state_d = ST_PRESET;
                    ptr_d   = '0;
                    err_d   = read | write;
                end else if (read && write) begin
                    err_d = 1'b1;
                end else if (write) begin
                    mem_we = 1'b1;
                end else if (read) begin
                    rd_data_d  = mem_q[address];
                    rd_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Array has no reset; writes are held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (mem_we && reset) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign data     = rd_valid_q ? rd_data_q : 'z;
    assign busy     = (state_q != ST_IDLE);
    assign rd_valid = rd_valid_q;
    assign err      = err_q;

endmodule
